// File: rtl/etapa_busqueda.sv
// etapa_busqueda: instruction-fetch stage with PC, imem req/ack handshake, stall buffer and redirect flush
module etapa_busqueda #(
  parameter int ANCHO = 32,
  parameter logic [ANCHO-1:0] PC_RESET = '0,
  parameter int INCREMENTO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] pc_siguiente,
  input  logic             salto_tomado,
  input  logic             detener,
  output logic             imem_req,
  output logic [ANCHO-1:0] imem_dir,
  input  logic             imem_ack,
  input  logic [ANCHO-1:0] imem_dato,
  output logic [ANCHO-1:0] pc_actual,
  output logic [ANCHO-1:0] pc_mas4,
  output logic [ANCHO-1:0] if_instr,
  output logic [ANCHO-1:0] if_pc,
  output logic             if_valido
);
  typedef enum logic [1:0] {INACTIVO, ESPERA, DETENIDO} estado_t;
  estado_t estado_q, estado_d;
  logic [ANCHO-1:0] pc_q, pc_d, dir_q, dir_d, instr_q, instr_d, ifpc_q, ifpc_d;
  logic [ANCHO-1:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;
  logic req_q, req_d, valido_q, valido_d, descartar_q, descartar_d;
  assign pc_mas4   = pc_q + ANCHO'(INCREMENTO);
  assign pc_actual = pc_q;
  assign imem_dir  = dir_q;
  assign imem_req  = req_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign if_valido = valido_q;
  always_comb begin
    estado_d    = estado_q;
    pc_d        = pc_q;
    dir_d       = dir_q;
    req_d       = req_q;
    instr_d     = instr_q;
    ifpc_d      = ifpc_q;
    valido_d    = valido_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    descartar_d = descartar_q;
    case (estado_q)
      INACTIVO: begin
        estado_d = ESPERA;
        req_d    = 1'b1;
        pc_d     = salto_tomado ? pc_siguiente : pc_q;
        dir_d    = salto_tomado ? pc_siguiente : pc_q;
        valido_d = salto_tomado ? 1'b0 : valido_q;
      end
      ESPERA: begin
        // a redirect with no ack leaves the request open; its late data is dropped
        if (salto_tomado) begin
          valido_d    = 1'b0;
          pc_d        = pc_siguiente;
          dir_d       = imem_ack ? pc_siguiente : dir_q;
          descartar_d = !imem_ack;
        end else if (imem_ack && descartar_q) begin
          dir_d       = pc_q;
          descartar_d = 1'b0;
        end else if (imem_ack && detener) begin
          buf_instr_d = imem_dato;
          buf_pc_d    = dir_q;
          req_d       = 1'b0;
          estado_d    = DETENIDO;
        end else if (imem_ack) begin
          instr_d  = imem_dato;
          ifpc_d   = dir_q;
          valido_d = 1'b1;
          pc_d     = pc_siguiente;
          dir_d    = pc_siguiente;
        end else if (!detener) begin
          valido_d = 1'b0;
        end
      end
      DETENIDO: begin
        if (salto_tomado || !detener) begin
          pc_d     = pc_siguiente;
          dir_d    = pc_siguiente;
          req_d    = 1'b1;
          estado_d = ESPERA;
          valido_d = !salto_tomado;
          instr_d  = salto_tomado ? instr_q : buf_instr_q;
          ifpc_d   = salto_tomado ? ifpc_q : buf_pc_q;
        end
      end
      default: estado_d = INACTIVO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= INACTIVO;
      pc_q        <= PC_RESET;
      dir_q       <= PC_RESET;
      req_q       <= 1'b0;
      instr_q     <= '0;
      ifpc_q      <= '0;
      valido_q    <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      descartar_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      pc_q        <= pc_d;
      dir_q       <= dir_d;
      req_q       <= req_d;
      instr_q     <= instr_d;
      ifpc_q      <= ifpc_d;
      valido_q    <= valido_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      descartar_q <= descartar_d;
    end
  end
endmodule

// File: tb/tb_etapa_busqueda.sv
// tb_etapa_busqueda: directed checks of the fetch stage with a 0x1000+addr memory model
module tb_etapa_busqueda;
  logic clk = 0, rst_n = 0, salto_tomado = 0, detener = 0, imem_ack = 0, usar_destino = 0;
  logic [31:0] destino = 0;
  logic imem_req, if_valido;
  logic [31:0] pc_siguiente, imem_dir, imem_dato, pc_actual, pc_mas4, if_instr, if_pc;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign pc_siguiente = usar_destino ? destino : pc_mas4;
  assign imem_dato = 32'h1000 + imem_dir;
  etapa_busqueda dut (
    .clk(clk), .rst_n(rst_n), .pc_siguiente(pc_siguiente), .salto_tomado(salto_tomado),
    .detener(detener), .imem_req(imem_req), .imem_dir(imem_dir), .imem_ack(imem_ack),
    .imem_dato(imem_dato), .pc_actual(pc_actual), .pc_mas4(pc_mas4), .if_instr(if_instr),
    .if_pc(if_pc), .if_valido(if_valido)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    tick(2);
    checks += 7;
    if (pc_actual !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_actual); end
    if (imem_dir !== 32'h0) begin errors++; $display("FAIL reset_dir got=%h exp=0", imem_dir); end
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    if (if_valido !== 1'b0) begin errors++; $display("FAIL reset_valido got=%b exp=0", if_valido); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_ifpc got=%h exp=0", if_pc); end
    if (pc_mas4 !== 32'h4) begin errors++; $display("FAIL reset_mas4 got=%h exp=4", pc_mas4); end
    rst_n = 1;
    tick();
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL inactivo_req got=%b exp=1", imem_req); end
    if (if_valido !== 1'b0) begin errors++; $display("FAIL inactivo_valido got=%b exp=0", if_valido); end
  endtask
  task automatic test_sequential;
    imem_ack = 1;
    tick();
    checks += 3;
    if (if_pc !== 32'h0 || if_valido !== 1'b1) begin errors++; $display("FAIL seq0 if_pc=%h valido=%b exp=0/1", if_pc, if_valido); end
    if (if_instr !== 32'h1000) begin errors++; $display("FAIL seq0_instr got=%h exp=1000", if_instr); end
    if (imem_dir !== 32'h4) begin errors++; $display("FAIL seq0_dir got=%h exp=4", imem_dir); end
    tick();
    checks += 2;
    if (if_pc !== 32'h4 || if_valido !== 1'b1) begin errors++; $display("FAIL seq1 if_pc=%h valido=%b exp=4/1", if_pc, if_valido); end
    if (if_instr !== 32'h1004) begin errors++; $display("FAIL seq1_instr got=%h exp=1004", if_instr); end
  endtask
  task automatic test_stall;
    detener = 1;
    tick();
    checks += 3;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got=%b exp=0", imem_req); end
    if (if_pc !== 32'h4 || if_instr !== 32'h1004 || if_valido !== 1'b1) begin errors++; $display("FAIL stall_hold if_pc=%h instr=%h valido=%b exp=4/1004/1", if_pc, if_instr, if_valido); end
    if (pc_actual !== 32'h8) begin errors++; $display("FAIL stall_pc got=%h exp=8", pc_actual); end
    tick(2);
    checks += 1;
    if (if_pc !== 32'h4 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold3 if_pc=%h req=%b exp=4/0", if_pc, imem_req); end
    detener = 0;
    tick();
    checks += 2;
    if (if_pc !== 32'h8 || if_instr !== 32'h1008 || if_valido !== 1'b1) begin errors++; $display("FAIL release if_pc=%h instr=%h valido=%b exp=8/1008/1", if_pc, if_instr, if_valido); end
    if (imem_req !== 1'b1 || imem_dir !== 32'hC) begin errors++; $display("FAIL release_req req=%b dir=%h exp=1/c", imem_req, imem_dir); end
    tick();
    checks += 1;
    if (if_pc !== 32'hC || if_instr !== 32'h100C) begin errors++; $display("FAIL resume if_pc=%h instr=%h exp=c/100c", if_pc, if_instr); end
  endtask
  task automatic test_branch_wait;
    imem_ack = 0;
    tick(2);
    checks += 2;
    if (if_valido !== 1'b0) begin errors++; $display("FAIL bubble_valido got=%b exp=0", if_valido); end
    if (imem_dir !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_dir dir=%h req=%b exp=10/1", imem_dir, imem_req); end
    salto_tomado = 1; usar_destino = 1; destino = 32'h200;
    tick();
    checks += 2;
    if (imem_dir !== 32'h10) begin errors++; $display("FAIL branch_dir_hold got=%h exp=10", imem_dir); end
    if (pc_actual !== 32'h200) begin errors++; $display("FAIL branch_pc got=%h exp=200", pc_actual); end
    salto_tomado = 0; usar_destino = 0; imem_ack = 1;
    tick();
    checks += 2;
    if (imem_dir !== 32'h200) begin errors++; $display("FAIL discard_dir got=%h exp=200", imem_dir); end
    if (if_valido !== 1'b0 || if_pc !== 32'hC) begin errors++; $display("FAIL discard_drop valido=%b if_pc=%h exp=0/c", if_valido, if_pc); end
    tick();
    checks += 1;
    if (if_pc !== 32'h200 || if_instr !== 32'h1200 || if_valido !== 1'b1) begin errors++; $display("FAIL target if_pc=%h instr=%h valido=%b exp=200/1200/1", if_pc, if_instr, if_valido); end
  endtask
  task automatic test_branch_stalled;
    detener = 1;
    tick();
    salto_tomado = 1; usar_destino = 1; destino = 32'h300;
    tick();
    checks += 2;
    if (if_valido !== 1'b0) begin errors++; $display("FAIL flush_valido got=%b exp=0", if_valido); end
    if (imem_req !== 1'b1 || imem_dir !== 32'h300 || pc_actual !== 32'h300) begin errors++; $display("FAIL flush_req req=%b dir=%h pc=%h exp=1/300/300", imem_req, imem_dir, pc_actual); end
    salto_tomado = 0; usar_destino = 0; detener = 0;
    tick();
    checks += 1;
    if (if_pc !== 32'h300 || if_instr !== 32'h1300 || if_valido !== 1'b1) begin errors++; $display("FAIL after_flush if_pc=%h instr=%h valido=%b exp=300/1300/1", if_pc, if_instr, if_valido); end
  endtask
  task automatic test_wrap;
    salto_tomado = 1; usar_destino = 1; destino = 32'hFFFF_FFFC;
    tick();
    checks += 2;
    if (pc_mas4 !== 32'h0) begin errors++; $display("FAIL wrap_mas4 got=%h exp=0", pc_mas4); end
    if (if_valido !== 1'b0 || imem_dir !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect valido=%b dir=%h exp=0/fffffffc", if_valido, imem_dir); end
    salto_tomado = 0; usar_destino = 0;
    tick();
    checks += 1;
    if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h0000_0FFC) begin errors++; $display("FAIL wrap_last if_pc=%h instr=%h exp=fffffffc/ffc", if_pc, if_instr); end
    tick();
    checks += 1;
    if (if_pc !== 32'h0 || if_instr !== 32'h1000 || if_valido !== 1'b1) begin errors++; $display("FAIL wrap_zero if_pc=%h instr=%h valido=%b exp=0/1000/1", if_pc, if_instr, if_valido); end
  endtask
  task automatic test_reset_mid;
    imem_ack = 0;
    tick();
    rst_n = 0;
    tick();
    checks += 2;
    if (pc_actual !== 32'h0 || imem_dir !== 32'h0) begin errors++; $display("FAIL midreset_pc pc=%h dir=%h exp=0/0", pc_actual, imem_dir); end
    if (if_valido !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL midreset_ctl valido=%b req=%b exp=0/0", if_valido, imem_req); end
    rst_n = 1; imem_ack = 1;
    tick();
    checks += 1;
    if (if_valido !== 1'b0 || imem_req !== 1'b1 || imem_dir !== 32'h0) begin errors++; $display("FAIL late_ack valido=%b req=%b dir=%h exp=0/1/0", if_valido, imem_req, imem_dir); end
    tick();
    checks += 1;
    if (if_pc !== 32'h0 || if_instr !== 32'h1000 || if_valido !== 1'b1) begin errors++; $display("FAIL first_after_reset if_pc=%h instr=%h valido=%b exp=0/1000/1", if_pc, if_instr, if_valido); end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_stalled();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
